// File: rtl/serdes_pkg.sv
// Shared types and defaults for the serializer front end.
package serdes_pkg;

   typedef enum logic {
      IDLE,
      SHIFT
   } ser_state_t;

   localparam int unsigned SER_WIDTH_DEF = 8;

endpackage

// File: rtl/bit_serializer_if.sv
// Word handshake and qualified serial stream between producer, serializer and detector.
interface bit_serializer_if #(
   parameter int unsigned WIDTH = serdes_pkg::SER_WIDTH_DEF
) ();

   logic [WIDTH-1:0] data_in;
   logic             data_valid;
   logic             data_ready;
   logic             in_bit;
   logic             bit_valid;
   logic             word_done;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready,
      input  in_bit,
      input  bit_valid,
      input  word_done
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready,
      output in_bit,
      output bit_valid,
      output word_done
   );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out front end: one shifting word plus a one-word pending buffer,
// emitting one registered bit per clock with bit_valid/word_done qualifiers.
module bit_serializer
   import serdes_pkg::*;
#(
   parameter int unsigned WIDTH     = SER_WIDTH_DEF,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   bit_serializer_if.slave  bus
);

   localparam int unsigned      CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   ser_state_t       r_state, w_state_nxt;
   logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
   logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
   logic [WIDTH-1:0] r_pend, w_pend_nxt;
   logic             r_pend_valid, w_pend_valid_nxt;
   logic             r_in_bit, w_in_bit_nxt;
   logic             r_bit_valid, w_bit_valid_nxt;
   logic             r_word_done, w_word_done_nxt;

   logic             w_accept;
   logic             w_last;
   logic             w_load;
   logic [WIDTH-1:0] w_src;
   logic [CNT_W-1:0] w_cnt_inc;

   function automatic logic f_head(input logic [WIDTH-1:0] word);
      return MSB_FIRST ? word[WIDTH-1] : word[0];
   endfunction

   function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] word);
      return MSB_FIRST ? {word[WIDTH-2:0], 1'b0} : {1'b0, word[WIDTH-1:1]};
   endfunction

   assign w_accept  = bus.data_valid & ~r_pend_valid;
   assign w_last    = (r_bit_cnt == LAST);
   assign w_cnt_inc = r_bit_cnt + CNT_W'(1);

   // The head bit is moved into r_in_bit on the same edge a word is loaded, so
   // r_shreg only ever holds the bits still to be sent; this keeps in_bit registered
   // while giving first-bit latency of one cycle.
   always_comb begin
      w_state_nxt      = r_state;
      w_shreg_nxt      = r_shreg;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_pend_nxt       = r_pend;
      w_pend_valid_nxt = r_pend_valid;
      w_in_bit_nxt     = r_in_bit;
      w_bit_valid_nxt  = r_bit_valid;
      w_word_done_nxt  = 1'b0;
      w_load           = 1'b0;
      w_src            = bus.data_in;

      unique case (r_state)
         IDLE: begin
            w_in_bit_nxt    = 1'b0;
            w_bit_valid_nxt = 1'b0;
            if (w_accept) begin
               w_load = 1'b1;
            end
         end
         SHIFT: begin
            if (w_last) begin
               if (r_pend_valid) begin
                  w_load           = 1'b1;
                  w_src            = r_pend;
                  w_pend_valid_nxt = 1'b0;
               end else if (w_accept) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt     = IDLE;
                  w_in_bit_nxt    = 1'b0;
                  w_bit_valid_nxt = 1'b0;
               end
            end else begin
               w_in_bit_nxt    = f_head(r_shreg);
               w_shreg_nxt     = f_shift(r_shreg);
               w_bit_cnt_nxt   = w_cnt_inc;
               w_word_done_nxt = (w_cnt_inc == LAST);
               if (w_accept) begin
                  w_pend_nxt       = bus.data_in;
                  w_pend_valid_nxt = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      if (w_load) begin
         w_state_nxt     = SHIFT;
         w_in_bit_nxt    = f_head(w_src);
         w_shreg_nxt     = f_shift(w_src);
         w_bit_cnt_nxt   = '0;
         w_bit_valid_nxt = 1'b1;
         w_word_done_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shreg      <= '0;
         r_bit_cnt    <= '0;
         r_pend       <= '0;
         r_pend_valid <= 1'b0;
         r_in_bit     <= 1'b0;
         r_bit_valid  <= 1'b0;
         r_word_done  <= 1'b0;
      end else begin
         r_shreg      <= w_shreg_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_pend       <= w_pend_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_in_bit     <= w_in_bit_nxt;
         r_bit_valid  <= w_bit_valid_nxt;
         r_word_done  <= w_word_done_nxt;
      end
   end

   assign bus.data_ready = ~r_pend_valid;
   assign bus.in_bit     = r_in_bit;
   assign bus.bit_valid  = r_bit_valid;
   assign bus.word_done  = r_word_done;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one MSB-first and one LSB-first instance.
module tb_bit_serializer;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   bit_serializer_if #(.WIDTH(8)) m_if ();
   bit_serializer_if #(.WIDTH(8)) l_if ();

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
      .clk   (clk),
      .reset (reset),
      .bus   (m_if.slave)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
      .clk   (clk),
      .reset (reset),
      .bus   (l_if.slave)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // seq[7] is the bit expected in the first serial cycle, seq[0] in the last.
   task automatic send_check(input bit lsb, input logic [7:0] w, input logic [7:0] seq,
                             input string tag);
      logic ib, bv, wd;
      if (lsb) begin l_if.data_in = w; l_if.data_valid = 1'b1; end
      else     begin m_if.data_in = w; m_if.data_valid = 1'b1; end
      tick();
      l_if.data_valid = 1'b0;
      m_if.data_valid = 1'b0;
      for (int k = 0; k < 9; k++) begin
         ib = lsb ? l_if.in_bit    : m_if.in_bit;
         bv = lsb ? l_if.bit_valid : m_if.bit_valid;
         wd = lsb ? l_if.word_done : m_if.word_done;
         if (k < 8) begin
            chk($sformatf("%s bit%0d", tag, k), 32'(ib), 32'(seq[7-k]));
            chk($sformatf("%s valid%0d", tag, k), 32'(bv), 32'd1);
            chk($sformatf("%s done%0d", tag, k), 32'(wd), (k == 7) ? 32'd1 : 32'd0);
         end else begin
            chk($sformatf("%s valid_after", tag), 32'(bv), 32'd0);
            chk($sformatf("%s bit_after", tag), 32'(ib), 32'd0);
         end
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0]  words [3];
      int          idx, nbv, nlow, first, last, pos, hits;
      logic [31:0] stream, dmask;
      logic [2:0]  hist;
      logic        acc, hit_wd;

      reset = 1'b1;
      m_if.data_in = '0; m_if.data_valid = 1'b0;
      l_if.data_in = '0; l_if.data_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      for (int c = 0; c < 5; c++) begin
         chk($sformatf("idle ready%0d", c), 32'(m_if.data_ready), 32'd1);
         chk($sformatf("idle valid%0d", c), 32'(m_if.bit_valid), 32'd0);
         chk($sformatf("idle bit%0d", c), 32'(m_if.in_bit), 32'd0);
         tick();
      end

      send_check(1'b0, 8'hA5, 8'b10100101, "msb A5");
      send_check(1'b1, 8'hA5, 8'b10100101, "lsb A5");
      send_check(1'b1, 8'h01, 8'b10000000, "lsb 01");

      // Continuous producer: three words, each offered until accepted.
      words = '{8'hF0, 8'h0F, 8'hCC};
      idx = 0; nbv = 0; nlow = 0; first = -1; last = -1; pos = 0;
      stream = '0; dmask = '0;
      for (int c = 0; c < 30; c++) begin
         if (m_if.bit_valid) begin
            pos++; nbv++;
            stream = {stream[30:0], m_if.in_bit};
            if (m_if.word_done) dmask = dmask | (32'd1 << pos);
            if (first < 0) first = c;
            last = c;
         end else if (m_if.word_done) begin
            dmask = dmask | 32'h8000_0000;
         end
         if (!m_if.data_ready) nlow++;
         m_if.data_valid = (idx < 3);
         m_if.data_in    = (idx < 3) ? words[idx] : 8'h00;
         acc = m_if.data_valid && m_if.data_ready;
         tick();
         if (acc) idx++;
      end
      m_if.data_valid = 1'b0;
      chk("stream valid count", 32'(nbv), 32'd24);
      chk("stream contiguous", 32'(last - first + 1), 32'd24);
      chk("stream bits", stream, 32'h00F0_0FCC);
      chk("stream done pulses", dmask, 32'h0101_0100);
      chk("stream ready low", 32'(nlow), 32'd14);
      chk("stream words taken", 32'(idx), 32'd3);

      // Reset at bit 3 of FF with 00 pending.
      m_if.data_in = 8'hFF; m_if.data_valid = 1'b1;
      tick();
      m_if.data_in = 8'h00;
      tick();
      m_if.data_valid = 1'b0;
      tick();
      tick();
      chk("rst pre ready", 32'(m_if.data_ready), 32'd0);
      chk("rst pre valid", 32'(m_if.bit_valid), 32'd1);
      chk("rst pre bit", 32'(m_if.in_bit), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst async valid", 32'(m_if.bit_valid), 32'd0);
      chk("rst async bit", 32'(m_if.in_bit), 32'd0);
      chk("rst async done", 32'(m_if.word_done), 32'd0);
      chk("rst async ready", 32'(m_if.data_ready), 32'd1);
      @(posedge clk);
      #1 reset = 1'b0;
      nbv = 0; nlow = 0;
      for (int c = 0; c < 12; c++) begin
         if (m_if.bit_valid) nbv++;
         if (!m_if.data_ready) nlow++;
         tick();
      end
      chk("rst dropped valid", 32'(nbv), 32'd0);
      chk("rst dropped ready", 32'(nlow), 32'd0);

      // Overlapping 101 detector fed from in_bit every clock.
      hist = '0; hits = 0; hit_wd = 1'b0;
      m_if.data_in = 8'h05; m_if.data_valid = 1'b1;
      for (int c = 0; c < 13; c++) begin
         hist = {hist[1:0], m_if.in_bit};
         if (hist == 3'b101) begin
            hits++;
            hit_wd = m_if.word_done;
         end
         tick();
         m_if.data_valid = 1'b0;
      end
      chk("det hits", 32'(hits), 32'd1);
      chk("det on last bit", 32'(hit_wd), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
